// File: rtl/bnn_xnor_popcount_acc.sv
// Pipelined XNOR/popcount dot-product engine for binary neural networks.
// Accumulates multi-beat vectors and emits popcount or signed +/-1 dot product with threshold.
module bnn_xnor_popcount_acc #(
  parameter int WL    = 112,
  parameter int ACC_W = 16
) (
  input  logic             iCLK,
  input  logic             iRSTn,
  input  logic             iEN,
  input  logic             ivalid,
  input  logic             ilast,
  input  logic [WL-1:0]    idata,
  input  logic [WL-1:0]    iweight,
  input  logic [WL-1:0]    imask,
  input  logic             imode,
  input  logic [ACC_W-1:0] ithresh,
  output logic             ovalid,
  output logic [ACC_W-1:0] odata,
  output logic             osign,
  output logic             ooverflow
);

  localparam int PC_W = $clog2(WL + 1);
  localparam logic [ACC_W:0]          SAT_MAX = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W+1:0] D_MAX   = {3'b000, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W+1:0] D_MIN   = {3'b111, {(ACC_W-1){1'b0}}};

  function automatic logic [PC_W-1:0] popcnt(input logic [WL-1:0] v);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < WL; i++) c = c + PC_W'(v[i]);
    return c;
  endfunction

  logic [WL-1:0] xm_next;
  genvar gi;
  generate
    for (gi = 0; gi < WL; gi++) begin : g_xnor
      assign xm_next[gi] = ~(idata[gi] ^ iweight[gi]) & imask[gi];
    end
  endgenerate

  // S1
  logic             s1_valid_reg, s1_last_reg, s1_mode_reg;
  logic [WL-1:0]    s1_xm_reg, s1_mk_reg;
  logic [ACC_W-1:0] s1_thresh_reg;
  // S2
  logic             s2_valid_reg, s2_last_reg, s2_mode_reg;
  logic [PC_W-1:0]  s2_pop_reg, s2_nb_reg;
  logic [ACC_W-1:0] s2_thresh_reg;
  // S3 accumulators and result
  logic [ACC_W-1:0] acc_pop_reg, acc_n_reg;
  logic             ovf_acc_reg;
  logic             res_valid_reg, res_sign_reg, res_ovf_reg;
  logic [ACC_W-1:0] res_data_reg;
  // Output
  logic             ovalid_reg, osign_reg, ooverflow_reg;
  logic [ACC_W-1:0] odata_reg;

  logic [ACC_W:0]          sp_raw, sn_raw;
  logic                    sat_p, sat_n;
  logic [ACC_W-1:0]        sp_next, sn_next;
  logic signed [ACC_W+1:0] dot_raw;
  logic                    dot_hi, dot_lo;
  logic [ACC_W-1:0]        res_data_next;
  logic                    res_sign_next, res_ovf_next;

  always_comb begin
    sp_raw  = {1'b0, acc_pop_reg} + (ACC_W+1)'(s2_pop_reg);
    sn_raw  = {1'b0, acc_n_reg} + (ACC_W+1)'(s2_nb_reg);
    sat_p   = sp_raw > SAT_MAX;
    sat_n   = sn_raw > SAT_MAX;
    sp_next = sat_p ? SAT_MAX[ACC_W-1:0] : sp_raw[ACC_W-1:0];
    sn_next = sat_n ? SAT_MAX[ACC_W-1:0] : sn_raw[ACC_W-1:0];
    // Two extra bits cover the full 2*sp - sn range before clamping.
    dot_raw = $signed({1'b0, sp_next, 1'b0}) - $signed({2'b00, sn_next});
    dot_hi  = dot_raw > D_MAX;
    dot_lo  = dot_raw < D_MIN;
    if (!s2_mode_reg)
      res_data_next = sp_next;
    else if (dot_hi)
      res_data_next = D_MAX[ACC_W-1:0];
    else if (dot_lo)
      res_data_next = D_MIN[ACC_W-1:0];
    else
      res_data_next = dot_raw[ACC_W-1:0];
    res_sign_next = $signed(res_data_next) >= $signed(s2_thresh_reg);
    res_ovf_next  = ovf_acc_reg | sat_p | sat_n | (s2_mode_reg & (dot_hi | dot_lo));
  end

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      s1_valid_reg  <= 1'b0;
      s1_last_reg   <= 1'b0;
      s1_mode_reg   <= 1'b0;
      s1_xm_reg     <= '0;
      s1_mk_reg     <= '0;
      s1_thresh_reg <= '0;
      s2_valid_reg  <= 1'b0;
      s2_last_reg   <= 1'b0;
      s2_mode_reg   <= 1'b0;
      s2_pop_reg    <= '0;
      s2_nb_reg     <= '0;
      s2_thresh_reg <= '0;
      acc_pop_reg   <= '0;
      acc_n_reg     <= '0;
      ovf_acc_reg   <= 1'b0;
      res_valid_reg <= 1'b0;
      res_data_reg  <= '0;
      res_sign_reg  <= 1'b0;
      res_ovf_reg   <= 1'b0;
      ovalid_reg    <= 1'b0;
      odata_reg     <= '0;
      osign_reg     <= 1'b0;
      ooverflow_reg <= 1'b0;
    end else if (iEN) begin
      s1_valid_reg  <= ivalid;
      s1_last_reg   <= ivalid & ilast;
      s1_mode_reg   <= imode;
      s1_xm_reg     <= xm_next;
      s1_mk_reg     <= imask;
      s1_thresh_reg <= ithresh;

      s2_valid_reg  <= s1_valid_reg;
      s2_last_reg   <= s1_last_reg;
      s2_mode_reg   <= s1_mode_reg;
      s2_pop_reg    <= popcnt(s1_xm_reg);
      s2_nb_reg     <= popcnt(s1_mk_reg);
      s2_thresh_reg <= s1_thresh_reg;

      if (s2_valid_reg) begin
        if (s2_last_reg) begin
          acc_pop_reg <= '0;
          acc_n_reg   <= '0;
          ovf_acc_reg <= 1'b0;
        end else begin
          acc_pop_reg <= sp_next;
          acc_n_reg   <= sn_next;
          ovf_acc_reg <= ovf_acc_reg | sat_p | sat_n;
        end
      end
      res_valid_reg <= s2_valid_reg & s2_last_reg;
      if (s2_valid_reg && s2_last_reg) begin
        res_data_reg <= res_data_next;
        res_sign_reg <= res_sign_next;
        res_ovf_reg  <= res_ovf_next;
      end

      // Final register stage; fields hold between strobes.
      ovalid_reg <= res_valid_reg;
      if (res_valid_reg) begin
        odata_reg     <= res_data_reg;
        osign_reg     <= res_sign_reg;
        ooverflow_reg <= res_ovf_reg;
      end
    end
  end

  // A pending strobe waits out a stall and shows once iEN is back.
  assign ovalid    = ovalid_reg & iEN;
  assign odata     = odata_reg;
  assign osign     = osign_reg;
  assign ooverflow = ooverflow_reg;

endmodule

// File: tb/tb_bnn_xnor_popcount_acc.sv
// Scoreboard bench for bnn_xnor_popcount_acc: a 16-bit accumulator instance plus an
// 8-bit instance on the same inputs for the saturation scenario.
module tb_bnn_xnor_popcount_acc;
  localparam int WL = 112;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, en, ivalid, ilast, imode;
  logic [WL-1:0] idata, iweight, imask;
  logic [15:0]   ithresh;
  logic          ovalid, osign, ooverflow;
  logic [15:0]   odata;
  logic          ovalid8, osign8, ooverflow8;
  logic [7:0]    odata8;

  bnn_xnor_popcount_acc #(.WL(WL), .ACC_W(16)) dut (
    .iCLK(clk), .iRSTn(rst_n), .iEN(en), .ivalid(ivalid), .ilast(ilast),
    .idata(idata), .iweight(iweight), .imask(imask), .imode(imode), .ithresh(ithresh),
    .ovalid(ovalid), .odata(odata), .osign(osign), .ooverflow(ooverflow));

  bnn_xnor_popcount_acc #(.WL(WL), .ACC_W(8)) dut8 (
    .iCLK(clk), .iRSTn(rst_n), .iEN(en), .ivalid(ivalid), .ilast(ilast),
    .idata(idata), .iweight(iweight), .imask(imask), .imode(imode), .ithresh(ithresh[7:0]),
    .ovalid(ovalid8), .odata(odata8), .osign(osign8), .ooverflow(ooverflow8));

  typedef struct packed {
    logic [15:0] data;
    logic        sign;
    logic        ovf;
    logic [31:0] cyc;
  } exp_t;

  exp_t q[$];
  exp_t q8[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [WL-1:0] all1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WL-1:0] rand_vec();
    logic [WL-1:0] v;
    for (int i = 0; i < WL; i++) v[i] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  function automatic logic [WL-1:0] lo(input int n);
    logic [WL-1:0] v;
    for (int i = 0; i < WL; i++) v[i] = (i < n);
    return v;
  endfunction

  function automatic exp_t mk(input logic [15:0] d, input logic s, input logic o, input int lat);
    exp_t e;
    e.data = d;
    e.sign = s;
    e.ovf  = o;
    e.cyc  = 32'(cyc + lat);
    return e;
  endfunction

  // Drives one accepted beat; returns one cycle later with ivalid low.
  task automatic beat(input logic [WL-1:0] d, input logic [WL-1:0] w, input logic [WL-1:0] m,
                      input logic last, input logic mode, input logic [15:0] thr);
    en = 1'b1; ivalid = 1'b1; idata = d; iweight = w; imask = m;
    ilast = last; imode = mode; ithresh = thr;
    tick();
    ivalid = 1'b0; ilast = 1'b0;
  endtask

  // Observes the next strobe within a cycle budget (no checking here).
  task automatic wait_out(input int budget, output bit got, output exp_t obs,
                          output bit got8, output exp_t obs8);
    got = 1'b0; got8 = 1'b0; obs = '0; obs8 = '0;
    for (int i = 0; i < budget; i++) begin
      if (ovalid) begin
        got  = 1'b1;
        obs  = {odata, osign, ooverflow, 32'(cyc)};
        got8 = ovalid8;
        obs8 = {8'h00, odata8, osign8, ooverflow8, 32'(cyc)};
      end
      tick();
      if (got) break;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; ivalid = 1'b0; ilast = 1'b0; imode = 1'b0;
    idata = '0; iweight = '0; imask = '0; ithresh = '0;
    tick(); tick();
    n_cmp++;
    if ({ovalid, odata, osign, ooverflow, ovalid8, odata8, osign8, ooverflow8} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got ovalid=%0b odata=%0d osign=%0b ovf=%0b, need all 0",
               ovalid, odata, osign, ooverflow);
    end
    rst_n = 1'b1; en = 1'b1;
    begin
      bit got, got8;
      exp_t obs, obs8;
      wait_out(6, got, obs, got8, obs8);
      n_cmp++;
      if (got) begin
        n_bad++;
        $display("FAIL reset_idle: got ovalid=1 odata=%0d, need no strobe", obs.data);
      end
    end
  endtask

  task automatic test_single_beat();
    logic [WL-1:0] w;
    bit got, got8;
    exp_t obs, obs8, e;
    w = rand_vec();
    beat(w, w, all1, 1'b1, 1'b1, 16'd0);
    q.push_back(mk(16'd112, 1'b1, 1'b0, 3));
    beat(~w, w, all1, 1'b1, 1'b1, 16'd0);
    q.push_back(mk(16'hFF90, 1'b0, 1'b0, 3));
    while (q.size() > 0) begin
      wait_out(10, got, obs, got8, obs8);
      e = q.pop_front();
      n_cmp++;
      if (!got || obs !== e) begin
        n_bad++;
        $display("FAIL single_beat: got(%0b) data=%0d sign=%0b ovf=%0b cyc=%0d, need data=%0d sign=%0b ovf=%0b cyc=%0d",
                 got, $signed(obs.data), obs.sign, obs.ovf, obs.cyc,
                 $signed(e.data), e.sign, e.ovf, e.cyc);
      end
    end
  endtask

  task automatic test_three_beat();
    logic [WL-1:0] w;
    logic          mode [3];
    logic [15:0]   thr  [3];
    logic [15:0]   dexp [3];
    logic          sexp [3];
    bit got, got8;
    exp_t obs, obs8, e;
    mode = '{1'b1, 1'b0, 1'b1};
    thr  = '{16'd0, 16'd0, 16'd57};
    dexp = '{16'd56, 16'd168, 16'd56};
    sexp = '{1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 3; k++) begin
      w = rand_vec();
      // Non-last beats carry the opposite mode and a huge threshold; only the last counts.
      beat(w, w, all1, 1'b0, ~mode[k], 16'h7FFF);
      beat(~w, w, all1, 1'b0, ~mode[k], 16'h7FFF);
      beat(w, w, lo(56), 1'b1, mode[k], thr[k]);
      q.push_back(mk(dexp[k], sexp[k], 1'b0, 3));
      wait_out(10, got, obs, got8, obs8);
      e = q.pop_front();
      n_cmp++;
      if (!got || obs !== e) begin
        n_bad++;
        $display("FAIL three_beat[%0d]: got(%0b) data=%0d sign=%0b ovf=%0b cyc=%0d, need data=%0d sign=%0b ovf=%0b cyc=%0d",
                 k, got, $signed(obs.data), obs.sign, obs.ovf, obs.cyc,
                 $signed(e.data), e.sign, e.ovf, e.cyc);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [WL-1:0] w;
    bit got, got8;
    exp_t obs, obs8, e;
    w = rand_vec();
    beat(w, w, all1, 1'b1, 1'b0, 16'd50);
    q.push_back(mk(16'd112, 1'b1, 1'b0, 3));
    beat(~w, w, all1, 1'b1, 1'b0, 16'd50);
    q.push_back(mk(16'd0, 1'b0, 1'b0, 3));
    beat(w, w, lo(50), 1'b1, 1'b0, 16'd50);
    q.push_back(mk(16'd50, 1'b1, 1'b0, 3));
    beat(w, w, lo(7), 1'b1, 1'b0, 16'd50);
    q.push_back(mk(16'd7, 1'b0, 1'b0, 3));
    while (q.size() > 0) begin
      wait_out(10, got, obs, got8, obs8);
      e = q.pop_front();
      n_cmp++;
      if (!got || obs !== e) begin
        n_bad++;
        $display("FAIL back_to_back: got(%0b) data=%0d sign=%0b ovf=%0b cyc=%0d, need data=%0d sign=%0b ovf=%0b cyc=%0d",
                 got, obs.data, obs.sign, obs.ovf, obs.cyc, e.data, e.sign, e.ovf, e.cyc);
      end
    end
  endtask

  task automatic test_stall();
    logic [WL-1:0] w;
    bit got, got8;
    exp_t obs, obs8, e;
    w = rand_vec();
    beat(w, w, all1, 1'b0, 1'b0, 16'd0);
    for (int k = 0; k < 5; k++) begin
      en = 1'b0; ivalid = 1'b1; ilast = 1'b1; idata = rand_vec(); imask = all1;
      #1;
      n_cmp++;
      if (ovalid !== 1'b0) begin
        n_bad++;
        $display("FAIL stall_between_beats: got ovalid=%0b, need 0", ovalid);
      end
      tick();
    end
    beat(w, w, lo(20), 1'b1, 1'b0, 16'd100);
    // Three stalled cycles follow while the last beat sits in S2.
    q.push_back(mk(16'd132, 1'b1, 1'b0, 6));
    tick();
    for (int k = 0; k < 3; k++) begin
      en = 1'b0; ivalid = 1'b1; ilast = 1'b1; idata = ~w;
      #1;
      n_cmp++;
      if (ovalid !== 1'b0) begin
        n_bad++;
        $display("FAIL stall_in_s2: got ovalid=%0b, need 0", ovalid);
      end
      tick();
    end
    en = 1'b1; ivalid = 1'b0; ilast = 1'b0;
    wait_out(12, got, obs, got8, obs8);
    e = q.pop_front();
    n_cmp++;
    if (!got || obs !== e) begin
      n_bad++;
      $display("FAIL stall_result: got(%0b) data=%0d sign=%0b ovf=%0b cyc=%0d, need data=%0d sign=%0b ovf=%0b cyc=%0d",
               got, obs.data, obs.sign, obs.ovf, obs.cyc, e.data, e.sign, e.ovf, e.cyc);
    end
    wait_out(8, got, obs, got8, obs8);
    n_cmp++;
    if (got || odata !== 16'd132) begin
      n_bad++;
      $display("FAIL stall_no_extra: got strobe=%0b odata=%0d, need strobe=0 odata=132", got, odata);
    end
  endtask

  task automatic test_saturation();
    logic [WL-1:0] w;
    bit got, got8;
    exp_t obs, obs8, e, e8;
    w = rand_vec();
    for (int v = 0; v < 2; v++) begin
      if (v == 0) begin
        beat(w, w, all1, 1'b0, 1'b0, 16'd0);
        beat(w, w, all1, 1'b0, 1'b0, 16'd0);
        beat(w, w, all1, 1'b1, 1'b0, 16'd0);
        q.push_back(mk(16'd336, 1'b1, 1'b0, 3));
        q8.push_back(mk(16'd127, 1'b1, 1'b1, 3));
      end else begin
        beat(w, w, lo(5), 1'b1, 1'b0, 16'd0);
        q.push_back(mk(16'd5, 1'b1, 1'b0, 3));
        q8.push_back(mk(16'd5, 1'b1, 1'b0, 3));
      end
      wait_out(10, got, obs, got8, obs8);
      e  = q.pop_front();
      e8 = q8.pop_front();
      n_cmp++;
      if (!got || obs !== e) begin
        n_bad++;
        $display("FAIL sat_acc16[%0d]: got(%0b) data=%0d sign=%0b ovf=%0b, need data=%0d sign=%0b ovf=%0b",
                 v, got, obs.data, obs.sign, obs.ovf, e.data, e.sign, e.ovf);
      end
      n_cmp++;
      if (!got8 || obs8 !== e8) begin
        n_bad++;
        $display("FAIL sat_acc8[%0d]: got(%0b) data=%0d sign=%0b ovf=%0b cyc=%0d, need data=%0d sign=%0b ovf=%0b cyc=%0d",
                 v, got8, obs8.data, obs8.sign, obs8.ovf, obs8.cyc, e8.data, e8.sign, e8.ovf, e8.cyc);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [WL-1:0] w;
    bit got, got8;
    exp_t obs, obs8, e;
    w = rand_vec();
    beat(w, w, all1, 1'b1, 1'b0, 16'd0);
    q.push_back(mk(16'd112, 1'b1, 1'b0, 3));
    beat(w, w, all1, 1'b0, 1'b0, 16'd0);
    wait_out(10, got, obs, got8, obs8);
    e = q.pop_front();
    n_cmp++;
    if (!got || obs !== e) begin
      n_bad++;
      $display("FAIL reset_mid_pre: got(%0b) data=%0d cyc=%0d, need data=%0d cyc=%0d",
               got, obs.data, obs.cyc, e.data, e.cyc);
    end
    beat(w, w, all1, 1'b1, 1'b0, 16'd0);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({ovalid, odata, osign, ooverflow} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_outputs: got ovalid=%0b odata=%0d osign=%0b ovf=%0b, need all 0",
               ovalid, odata, osign, ooverflow);
    end
    tick();
    rst_n = 1'b1;
    wait_out(8, got, obs, got8, obs8);
    n_cmp++;
    if (got) begin
      n_bad++;
      $display("FAIL reset_mid_flush: got strobe data=%0d, need no strobe", obs.data);
    end
    beat(w, w, lo(7), 1'b1, 1'b0, 16'd0);
    q.push_back(mk(16'd7, 1'b1, 1'b0, 3));
    wait_out(10, got, obs, got8, obs8);
    e = q.pop_front();
    n_cmp++;
    if (!got || obs !== e) begin
      n_bad++;
      $display("FAIL reset_mid_fresh: got(%0b) data=%0d sign=%0b ovf=%0b cyc=%0d, need data=%0d sign=%0b ovf=%0b cyc=%0d",
               got, obs.data, obs.sign, obs.ovf, obs.cyc, e.data, e.sign, e.ovf, e.cyc);
    end
  endtask

  initial begin
    all1 = '1;
    test_reset();
    test_single_beat();
    test_three_beat();
    test_back_to_back();
    test_stall();
    test_saturation();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bnn_xnor_popcount_acc.md
Name: bnn_xnor_popcount_acc

Overview:
- Pipelined, parametrised binary-neural-network dot-product engine. Successor to the fixed 112-bit XNOR/popcount unit.
- Each beat carries WL activation bits and WL weight bits, plus a per-bit valid mask. The block accumulates beats across a multi-beat vector, which ends on the beat marked ilast.
- Per vector it emits one result: raw popcount or signed ±1 dot product, a thresholded binary activation, and an overflow flag.
- Sits between the weight/feature buffers and the next-layer activation packer.

Parameters:
- WL, 112, bits per beat.
- ACC_W, 16, width of odata and ithresh (signed two's complement); also the accumulator width.
- PC_W, $clog2(WL+1), localparam, width of the per-beat popcount.

Ports:
- iCLK  in  1  clock
- iRSTn  in  1  asynchronous active-low reset
- iEN  in  1  global enable; low stalls the entire pipeline
- ivalid  in  1  beat valid
- ilast  in  1  final beat of the vector; qualified by ivalid
- idata  in  WL  activation bits (1 = +1, 0 = -1)
- iweight  in  WL  weight bits
- imask  in  WL  1 = bit participates; 0 = bit excluded from both the popcount and the bit count
- imode  in  1  0 = popcount output, 1 = signed dot product (2*pop - nbits)
- ithresh  in  ACC_W  signed activation threshold
- ovalid  out  1  one-cycle result strobe
- odata  out  ACC_W  result
- osign  out  1  binary activation: 1 when odata >= ithresh, signed compare
- ooverflow  out  1  accumulator saturated during this vector

Behaviour:
- Reset is asynchronous and active-low. All pipeline registers, both accumulators, ovalid, odata, osign and ooverflow go to 0.
- Beat acceptance: a beat is accepted only when iEN && ivalid. If iEN is low, ivalid is ignored.
- imode and ithresh are sampled on the accepted ilast beat and carried down the pipeline. They may change freely between vectors.
- Pipeline (advances only while iEN = 1):
  - S1: register xm = ~(idata ^ iweight) & imask, mk = imask, valid, last, mode, thresh.
  - S2: pop = popcount(xm) and nb = popcount(mk), each PC_W bits. Carry valid, last, mode, thresh.
  - S3 (output/accumulate stage):
    - sp = acc_pop + pop and sn = acc_n + nb, computed at ACC_W+1 bits and saturated to 2^(ACC_W-1)-1.
    - If not last: acc_pop <= sp, acc_n <= sn, and any saturation sets the sticky ovf_acc.
    - If last: acc_pop, acc_n and ovf_acc all clear to 0.
    - If last: the result registers load from sp/sn as below.
- Results on a last beat:
  - mode 0: odata = sp.
  - mode 1: odata = 2*sp - sn, computed at ACC_W+2 bits, then saturated to the signed ACC_W range.
  - osign = ($signed(odata) >= $signed(thresh)).
  - ooverflow = ovf_acc | saturation on this beat | final-result saturation.
  - ovalid = 1.
- Latency: the ilast beat accepted at edge T gives ovalid = 1 after edge T+3, for exactly one cycle.
- Vectors may be issued back-to-back with no bubble. The beat after ilast starts a fresh accumulation; a new vector's first beat may share S3 timing with the previous vector's output without interference.
- Single-beat vectors (ivalid && ilast together) are legal.
- A beat with imask = 0 contributes 0 to both pop and nbits, but its ilast still produces output.
- Stall:
  - While iEN = 0, all S1/S2/S3 registers and accumulators hold; odata/osign/ooverflow hold.
  - ovalid is driven 0 in every cycle iEN = 0, and a result never strobes twice.
  - A result pending in the pipe emerges after iEN returns: ovalid delay = 3 + number of stalled cycles.
- Reset mid-vector discards the partial accumulation and any in-flight beats.
- odata, osign and ooverflow hold their last values between strobes; they are valid only with ovalid.

Test Plan:
- Reset check: assert iRSTn = 0 mid-traffic -> all outputs 0 on the same cycle; no ovalid until new beats arrive after release.
- Single beat, WL = 112, imask all 1, idata = iweight, imode = 1, ithresh = 0 -> after 3 cycles: ovalid = 1, odata = 112, osign = 1, ooverflow = 0. Repeat with idata = ~iweight -> odata = -112, osign = 0.
- Three-beat vector, imode = 1:
  - Beat 1: full match. Beat 2: full mismatch. Beat 3: imask = lower 56 bits, matched.
  - -> odata = 2*168 - 280 = 56. Rerun with imode = 0 -> odata = 168. ithresh = 57 -> osign = 0.
- Back-to-back single-beat vectors on 4 consecutive cycles with pops 112, 0, 50, 7 (imode = 0) -> 4 consecutive ovalid strobes, odata = 112, 0, 50, 7. No carry-over between vectors.
- Stall: two-beat vector; hold iEN = 0 for 5 cycles between the beats and again while the last beat is in S2 -> same odata; ovalid delayed by exactly the stalled cycles; ovalid never high while iEN = 0; ivalid pulses during the stall are ignored.
- Saturation, ACC_W = 8:
  - Three full-match beats, imode = 0 -> odata = 127, ooverflow = 1.
  - Next vector, single beat pop = 5 -> odata = 5, ooverflow = 0.
